q_8_34a_ctrl: RTL and testbench

Q_8_34A_CTRL -- requirements
Module: q_8_34a_ctrl

---
 rtl/q_8_34a_pkg.sv | 7 +
 rtl/q_8_34a.sv | 37 +++
 rtl/q_8_34a_wdog.sv | 16 +
 rtl/q_8_34a_ctrl.sv | 78 +++++++
 tb/tb_q_8_34a_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/q_8_34a_pkg.sv
// q_8_34a_pkg: shared sizes and controller state encoding for the ones-count block.
// data_size: width of the word being counted; r2_size: width of the count register.
package q_8_34a_pkg;
  localparam int data_size = 8;
  localparam int r2_size = $clog2(data_size + 1);
  typedef enum logic [2:0] {S_IDLE, S_INCR, S_TEST, S_CHK, S_DONE} ctrl_state_t;
endpackage

// File: rtl/q_8_34a.sv
// q_8_34a: ones-count datapath (r1 shifts left into E, r2 counts ones).
// Ports: clk, rst_b (sync, active-low), data_in, load_regs/incr_r2/shift (commands),
//        zero (r1 == 0), E (last shifted-out bit), cnt (r2).
module q_8_34a
  import q_8_34a_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [data_size-1:0] data_in,
  input  logic                 load_regs,
  input  logic                 incr_r2,
  input  logic                 shift,
  output logic                 zero,
  output logic                 E,
  output logic [r2_size-1:0]   cnt
);
  logic [data_size-1:0] r1;
  logic [r2_size-1:0] r2;
  // r2 loads all-ones so the unconditional first increment lands on 0
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r1 <= '0;
      r2 <= '0;
      E <= 1'b0;
    end else if (load_regs) begin
      r1 <= data_in;
      r2 <= '1;
      E <= 1'b0;
    end else if (incr_r2) begin
      r2 <= r2 + 1'b1;
    end else if (shift) begin
      {E, r1} <= {r1, 1'b0};
    end
  end
  assign zero = r1 == '0;
  assign cnt = r2;
endmodule

// File: rtl/q_8_34a_wdog.sv
// q_8_34a_wdog: busy-cycle watchdog for the ones-count controller.
// Ports: clk, rst (sync, active-high), busy (controller not idle),
//        timeout (high in the LIMIT-th consecutive busy cycle).
module q_8_34a_wdog #(
  parameter int LIMIT = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic timeout
);
  localparam int w = $clog2(LIMIT + 1);
  logic [w-1:0] cnt;
  always_ff @(posedge clk) cnt <= (rst || !busy || timeout) ? '0 : cnt + 1'b1;
  assign timeout = busy && cnt == w'(LIMIT - 1);
endmodule

// File: rtl/q_8_34a_ctrl.sv
// q_8_34a_ctrl: control FSM sequencing the ones-count datapath.
// Ports: clk, rst (sync, active-high), start, abort, zero (r1 == 0), E (shifted-out bit),
//        load_regs/incr_r2/shift (datapath commands), ready, busy, done (pulse), err (timeout pulse).
// Macro Q_8_34A_CTRL_TIMEOUT_EN adds the busy-cycle watchdog; otherwise err is tied low.
module q_8_34a_ctrl
  import q_8_34a_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4 * data_size + 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic zero,
  input  logic E,
  output logic load_regs,
  output logic incr_r2,
  output logic shift,
  output logic ready,
  output logic busy,
  output logic done,
  output logic err
);
  ctrl_state_t state, state_n;
  logic idle, kill, timeout;
  assign idle = state == S_IDLE;
`ifdef Q_8_34A_CTRL_TIMEOUT_EN
  q_8_34a_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk(clk),
    .rst(rst),
    .busy(!idle),
    .timeout(timeout)
  );
  assign err = timeout && !rst;
`else
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
  // abort/timeout only cancel a run; in idle, start wins over abort
  assign kill = rst || (!idle && (abort || timeout));
  assign busy = !rst && !idle;
  assign ready = !busy;
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    load_regs = 1'b0;
    incr_r2 = 1'b0;
    shift = 1'b0;
    done = 1'b0;
    case (state)
      S_IDLE: begin
        load_regs = start;
        state_n = start ? S_INCR : S_IDLE;
      end
      S_INCR: begin
        incr_r2 = 1'b1;
        state_n = S_TEST;
      end
      S_TEST: begin
        shift = !zero;
        state_n = zero ? S_DONE : S_CHK;
      end
      S_CHK: state_n = E ? S_INCR : S_TEST;
      S_DONE: begin
        done = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (kill) begin
      state_n = S_IDLE;
      load_regs = 1'b0;
      incr_r2 = 1'b0;
      shift = 1'b0;
      done = 1'b0;
    end
  end
endmodule

// File: tb/tb_q_8_34a_ctrl.sv
// tb_q_8_34a_ctrl: directed self-checking bench for the controller paired with its datapath.
module tb_q_8_34a_ctrl;
  import q_8_34a_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [data_size-1:0] data_in = '0;
  logic force_ctl = 1'b0, zero_f = 1'b0, e_f = 1'b0;
  logic zero_dp, e_dp, zero_c, e_c;
  logic load_regs, incr_r2, shift, ready, busy, done, err;
  logic [r2_size-1:0] cnt;
  int vectors = 0;
  int miscompares = 0;
  int nl, ni, ns, nd, ne, nbad;
  bit to;

  always #5 clk = ~clk;

  assign zero_c = force_ctl ? zero_f : zero_dp;
  assign e_c = force_ctl ? e_f : e_dp;

  q_8_34a_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .zero(zero_c), .E(e_c),
    .load_regs(load_regs), .incr_r2(incr_r2), .shift(shift),
    .ready(ready), .busy(busy), .done(done), .err(err)
  );

  q_8_34a dp (
    .clk(clk), .rst_b(~rst), .data_in(data_in), .load_regs(load_regs), .incr_r2(incr_r2),
    .shift(shift), .zero(zero_dp), .E(e_dp), .cnt(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // One run from a start pulse until ready returns, tallying commands per cycle.
  task automatic run(input logic [data_size-1:0] d, input bit restart, input bit ab0,
                     output int l, output int i, output int s, output int dn, output int e,
                     output int bad, output bit tmo);
    data_in = d;
    start = 1'b1;
    abort = ab0;
    l = 0; i = 0; s = 0; dn = 0; e = 0; bad = 0; tmo = 1'b1;
    for (int c = 0; c < 100; c++) begin
      smp();
      l += int'(load_regs);
      i += int'(incr_r2);
      s += int'(shift);
      dn += int'(done);
      e += int'(err);
      if (int'(load_regs) + int'(incr_r2) + int'(shift) > 1) bad++;
      if (c > 0 && ready) begin
        tmo = 1'b0;
        break;
      end
      cyc();
      start = restart && c == 2;
      abort = 1'b0;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    // reset: outputs quiet even with start high
    start = 1'b1;
    smp();
    chk("rst_load", load_regs, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    cyc();
    cyc();
    rst = 1'b0;
    start = 1'b0;
    smp();
    chk("idle_ready", ready, 1'b1);
    cyc();

    // zero data, cycle by cycle
    data_in = 8'h00;
    start = 1'b1;
    smp();
    chk("z_c0_load", load_regs, 1'b1);
    cyc();
    start = 1'b0;
    smp();
    chk("z_c1_incr", incr_r2, 1'b1);
    chk("z_c1_busy", busy, 1'b1);
    cyc();
    smp();
    chk("z_c2_cmds", {load_regs, incr_r2, shift, done}, 4'b0000);
    cyc();
    smp();
    chk("z_c3_done", done, 1'b1);
    cyc();
    smp();
    chk("z_c4_ready", ready, 1'b1);
    chk("z_c4_done", done, 1'b0);
    chk("z_cnt", cnt, 0);
    cyc();

    // mixed data
    run(8'b1011_0010, 1'b0, 1'b0, nl, ni, ns, nd, ne, nbad, to);
    chk("mx_timeout", to, 1'b0);
    chk("mx_loads", nl, 1);
    chk("mx_incr", ni, 5);
    chk("mx_shift", ns, 7);
    chk("mx_done", nd, 1);
    chk("mx_err", ne, 0);
    chk("mx_onehot", nbad, 0);
    chk("mx_cnt", cnt, 4);
    cyc();

    // all ones, with a second start while busy
    run(8'hFF, 1'b1, 1'b0, nl, ni, ns, nd, ne, nbad, to);
    chk("ff_timeout", to, 1'b0);
    chk("ff_loads", nl, 1);
    chk("ff_incr", ni, 9);
    chk("ff_shift", ns, 8);
    chk("ff_done", nd, 1);
    chk("ff_onehot", nbad, 0);
    chk("ff_cnt", cnt, 8);
    cyc();
    smp();
    chk("ff_noqueue_ready", ready, 1'b1);
    chk("ff_noqueue_load", load_regs, 1'b0);
    cyc();

    // abort at cycle 5 of an 8'hFF run
    data_in = 8'hFF;
    start = 1'b1;
    cyc();
    start = 1'b0;
    nd = 0;
    for (int c = 1; c < 5; c++) begin
      smp();
      nd += int'(done);
      if (c == 4) chk("ab_c4_incr", incr_r2, 1'b1);
      cyc();
    end
    abort = 1'b1;
    smp();
    chk("ab_c5_shift", shift, 1'b0);
    chk("ab_c5_busy", busy, 1'b1);
    cyc();
    abort = 1'b0;
    smp();
    nd += int'(done);
    chk("ab_c6_ready", ready, 1'b1);
    chk("ab_no_done", nd, 0);
    cyc();

    // abort together with start in idle: start wins, run completes
    run(8'h01, 1'b0, 1'b1, nl, ni, ns, nd, ne, nbad, to);
    chk("as_timeout", to, 1'b0);
    chk("as_loads", nl, 1);
    chk("as_incr", ni, 2);
    chk("as_shift", ns, 8);
    chk("as_done", nd, 1);
    chk("as_cnt", cnt, 1);
    cyc();

    // reset during S_CHK
    data_in = 8'hFF;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    smp();
    chk("rs_cmds", {load_regs, incr_r2, shift, done, err}, 5'b00000);
    chk("rs_ready", ready, 1'b1);
    chk("rs_busy", busy, 1'b0);
    cyc();
    rst = 1'b0;
    smp();
    chk("rs_idle_ready", ready, 1'b1);
    chk("rs_idle_incr", incr_r2, 1'b0);
    chk("rs_idle_done", done, 1'b0);
    cyc();

`ifdef Q_8_34A_CTRL_TIMEOUT_EN
    // watchdog: datapath never reports zero, E always 1
    force_ctl = 1'b1;
    zero_f = 1'b0;
    e_f = 1'b1;
    start = 1'b1;
    ne = 0;
    nd = 0;
    nl = -1;
    for (int c = 0; c < 60; c++) begin
      smp();
      if (err) begin
        ne++;
        if (nl < 0) nl = c;
      end
      nd += int'(done);
      cyc();
      start = 1'b0;
    end
    chk("wd_err_cycle", nl, 40);
    chk("wd_err_count", ne, 1);
    chk("wd_done", nd, 0);
    smp();
    chk("wd_ready", ready, 1'b1);
    force_ctl = 1'b0;
    cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
